otsdaq_reg_sequencer: RTL and testbench

//  Sequences decoded otsdaq UDP commands onto the single internal register bus.
//  - Input: header (flags, word count, 36-bit address) plus write-data words from the Ethernet RX path.
//  - Issues one bus transaction per 64-bit word, with auto-increment or fixed address.
//  - Read data goes to the TX response stream; a bus watchdog covers slaves that never ack.

---
 rtl/otsdaq_pkg.sv | 18 +
 rtl/reg_bus_watchdog.sv | 36 +++
 rtl/otsdaq_reg_sequencer.sv | 165 ++++++++++++++++
 tb/tb_otsdaq_reg_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otsdaq_pkg.sv
// Shared definitions for the otsdaq register sequencer: command flag bit positions,
// sequencer states and the read word substituted when a slave never answers.
package otsdaq_pkg;

    localparam int FLAG_WRITE = 0;
    localparam int FLAG_NOINC = 1;

    localparam logic [63:0] DEAD_WORD_DEFAULT = 64'hDEAD_DEAD_DEAD_DEAD;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_BUS,
        RD_BUS,
        RD_RSP
    } seq_state_t;

endpackage

// File: rtl/reg_bus_watchdog.sv
// Bus transaction watchdog: armed by start on the bus_req rise, disarmed by clear,
// expire is high in the TIMEOUT-th cycle of the transaction.
module reg_bus_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic             run;
    logic [CNT_W-1:0] cnt;

    // cnt equals the number of cycles bus_req has already been high before this one
    assign expire = run && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (clear || expire) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/otsdaq_reg_sequencer.sv
// Sequences decoded otsdaq UDP commands onto the internal register bus, one bus
// transaction per 64-bit word, returning read words on the TX response stream.
module otsdaq_reg_sequencer
    import otsdaq_pkg::*;
#(
    parameter int                ADDR_W    = 36,
    parameter int                DATA_W    = 64,
    parameter int                TIMEOUT   = 1023,
    parameter logic [DATA_W-1:0] DEAD_WORD = DATA_W'(DEAD_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_flags,
    input  logic [7:0]        cmd_nwords,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              err_timeout
);

    seq_state_t state, state_nx;

    logic       flag_noinc;
    logic [7:0] remaining;

    logic on_bus;
    logic ack_seen;
    logic timeout_hit;
    logic xfer_done;
    logic cmd_fire;
    logic wr_fire;
    logic rsp_fire;
    logic wd_start;
    logic wd_expire;
    logic unused_flags;

    assign unused_flags = ^cmd_flags[7:2];

    assign on_bus      = (state == WR_BUS) || (state == RD_BUS);
    assign ack_seen    = on_bus && bus_ack;
    // An ack landing in the expiry cycle completes the transaction normally.
    assign timeout_hit = on_bus && wd_expire && !bus_ack;
    assign xfer_done   = ack_seen || timeout_hit;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign wr_fire     = wr_valid && wr_ready;
    assign rsp_fire    = rsp_valid && rsp_ready;
    assign busy        = (state != IDLE);

    // Bus states never follow each other directly, so entering one is always a rise.
    assign wd_start = ((state_nx == WR_BUS) || (state_nx == RD_BUS)) && !on_bus;

    reg_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .start  (wd_start),
        .clear  (ack_seen),
        .expire (wd_expire)
    );

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = rstn;
                if (cmd_valid && rstn && (cmd_nwords != 8'd0)) begin
                    state_nx = cmd_flags[FLAG_WRITE] ? WR_DATA : RD_BUS;
                end
            end
            WR_DATA: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    state_nx = WR_BUS;
                end
            end
            WR_BUS: begin
                bus_req = 1'b1;
                bus_we  = 1'b1;
                if (xfer_done) begin
                    state_nx = (remaining == 8'd1) ? IDLE : WR_DATA;
                end
            end
            RD_BUS: begin
                bus_req = 1'b1;
                if (xfer_done) begin
                    state_nx = RD_RSP;
                end
            end
            RD_RSP: begin
                rsp_valid = 1'b1;
                rsp_last  = (remaining == 8'd1);
                if (rsp_ready) begin
                    state_nx = (remaining == 8'd1) ? IDLE : RD_BUS;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            flag_noinc  <= 1'b0;
            remaining   <= 8'd0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            rsp_data    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            err_timeout <= timeout_hit;

            if (cmd_fire) begin
                flag_noinc <= cmd_flags[FLAG_NOINC];
                remaining  <= cmd_nwords;
                bus_addr   <= cmd_addr;
            end

            if (wr_fire) begin
                bus_wdata <= wr_data;
            end

            if (state == RD_BUS) begin
                if (ack_seen) begin
                    rsp_data <= bus_rdata;
                end else if (timeout_hit) begin
                    rsp_data <= DEAD_WORD;
                end
            end

            // Address moves only after bus_req has been released for this word.
            if (xfer_done && !flag_noinc) begin
                bus_addr <= bus_addr + ADDR_W'(1);
            end

            if (((state == WR_BUS) && xfer_done) || rsp_fire) begin
                remaining <= remaining - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_otsdaq_reg_sequencer.sv
// Directed bench for otsdaq_reg_sequencer with a bus slave model and scoreboards
// for bus transactions and response words.
module tb_otsdaq_reg_sequencer;

    localparam int          TIMEOUT = 1023;
    localparam logic [63:0] DEAD    = 64'hDEAD_DEAD_DEAD_DEAD;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_flags;
    logic [7:0]  cmd_nwords;
    logic [35:0] cmd_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic        bus_req;
    logic        bus_we;
    logic [35:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_last;
    logic        busy;
    logic        err_timeout;

    otsdaq_reg_sequencer dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_flags   (cmd_flags),
        .cmd_nwords  (cmd_nwords),
        .cmd_addr    (cmd_addr),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [35:0] addr;
        logic        we;
        logic [63:0] wdata;
    } bus_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } rsp_t;

    bus_t        bus_exp[$];
    rsp_t        rsp_exp[$];
    logic [63:0] rd_q[$];

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    int ack_delay  = 2;
    int silent_req = 0;
    bit stray_ack  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: acks ack_delay cycles into bus_req; silent when the bench asks for it.
    initial begin
        int age;
        int silent_done;
        bit silent_cur;
        age = 0;
        silent_done = 0;
        silent_cur = 0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                if (age == 0) begin
                    silent_cur = (silent_req > silent_done);
                    if (silent_cur) silent_done++;
                end
                age++;
            end else begin
                age = 0;
            end
            bus_ack = 1'b0;
            bus_rdata = '0;
            if (stray_ack) begin
                bus_ack = 1'b1;
            end else if (bus_req && !silent_cur && age == ack_delay) begin
                bus_ack = 1'b1;
                if (!bus_we && rd_q.size() > 0) bus_rdata = rd_q.pop_front();
            end
        end
    end

    // Bus monitor plus timeout latency check.
    initial begin
        bit   prev;
        bit   stable;
        int   rise_cyc;
        bus_t cur;
        bus_t e;
        prev = 0;
        stable = 1;
        rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (bus_req && !prev) begin
                rise_cyc = cyc;
                cur.addr = bus_addr;
                cur.we = bus_we;
                cur.wdata = bus_wdata;
                stable = 1;
                check("bus_txn_expected", bus_exp.size() > 0, 1);
                if (bus_exp.size() > 0) begin
                    e = bus_exp.pop_front();
                    check("bus_addr", bus_addr, e.addr);
                    check("bus_we", bus_we, e.we);
                    if (e.we) check("bus_wdata", bus_wdata, e.wdata);
                end
            end else if (bus_req) begin
                if ({bus_addr, bus_we, bus_wdata} !== {cur.addr, cur.we, cur.wdata}) stable = 0;
            end else if (prev) begin
                check("bus_stable", stable, 1);
            end
            if (err_timeout) begin
                err_seen++;
                check("err_latency", cyc - rise_cyc, TIMEOUT);
            end
            prev = bus_req;
        end
    end

    // Response monitor.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", rsp_exp.size() > 0, 1);
                if (rsp_exp.size() > 0) begin
                    r = rsp_exp.pop_front();
                    check("rsp_data", rsp_data, r.data);
                    check("rsp_last", rsp_last, r.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bus(input logic [35:0] a, input logic we, input logic [63:0] d);
        bus_t b;
        b.addr = a;
        b.we = we;
        b.wdata = d;
        bus_exp.push_back(b);
    endtask

    task automatic push_rsp(input logic [63:0] d, input logic last);
        rsp_t r;
        r.data = d;
        r.last = last;
        rsp_exp.push_back(r);
    endtask

    task automatic send_cmd(input logic [7:0] f, input logic [7:0] n, input logic [35:0] a);
        bit ok;
        ok = 0;
        cmd_flags = f;
        cmd_nwords = n;
        cmd_addr = a;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
            tick();
        end
        cmd_valid = 1'b0;
        check("cmd_accept", ok, 1);
    endtask

    task automatic send_wr(input logic [63:0] d);
        bit ok;
        ok = 0;
        wr_data = d;
        wr_valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (wr_ready) ok = 1;
            tick();
        end
        wr_valid = 1'b0;
        check("wr_accept", ok, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        check(tag, ok, 1);
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {cmd_ready, wr_ready, bus_req, bus_we, rsp_valid, rsp_last, busy, err_timeout}, 0);
        check({tag, "_bus"}, {bus_addr, bus_wdata}, 0);
        check({tag, "_rsp"}, rsp_data, 0);
    endtask

    initial begin
        bit          ok;
        bit          seen;
        logic [35:0] a;
        logic [63:0] d;

        rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_flags = '0;
        cmd_nwords = '0;
        cmd_addr = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        tick();
        rstn = 1'b1;
        tick();

        // 1: single write, ack after 2 cycles, busy drops right after the ack
        ack_delay = 2;
        push_bus(36'h1, 1'b1, 64'h12345678);
        send_cmd(8'h01, 8'd1, 36'h1);
        send_wr(64'h12345678);
        ok = 0;
        seen = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus_req) seen = 1;
            else if (seen) ok = 1;
        end
        check("t1_req_fall", ok, 1);
        check("t1_busy_after_ack", busy, 0);
        tick();

        // 2: single read
        rd_q.push_back(64'hCAFE);
        push_bus(36'h0, 1'b0, 64'h0);
        push_rsp(64'hCAFE, 1'b1);
        send_cmd(8'h00, 8'd1, 36'h0);
        wait_idle("t2_idle");

        // 3: read burst across the address wrap
        a = 36'hF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            d = 64'hA000 + 64'(i);
            push_bus(a, 1'b0, 64'h0);
            rd_q.push_back(d);
            push_rsp(d, i == 2);
            a = a + 36'd1;
        end
        send_cmd(8'h00, 8'd3, 36'hF_FFFF_FFFF);
        wait_idle("t3_idle");

        // 4: non-incrementing write burst
        push_bus(36'h5, 1'b1, 64'h1111_2222_3333_4444);
        push_bus(36'h5, 1'b1, 64'h5555_6666_7777_8888);
        send_cmd(8'h03, 8'd2, 36'h5);
        send_wr(64'h1111_2222_3333_4444);
        send_wr(64'h5555_6666_7777_8888);
        wait_idle("t4_idle");

        // No-op command and stray ack while idle
        send_cmd(8'h01, 8'd0, 36'h77);
        ok = 1;
        stray_ack = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || bus_req || wr_ready || rsp_valid) ok = 0;
        end
        stray_ack = 0;
        tick();
        check("noop_quiet", ok, 1);

        // 5: read burst, slave silent on word 0
        silent_req = silent_req + 1;
        push_bus(36'h100, 1'b0, 64'h0);
        push_bus(36'h101, 1'b0, 64'h0);
        rd_q.push_back(64'h5555);
        push_rsp(DEAD, 1'b0);
        push_rsp(64'h5555, 1'b1);
        send_cmd(8'h00, 8'd2, 36'h100);
        wait_idle("t5_idle");
        check("t5_err_count", err_seen, 1);

        // Ack in the very cycle the watchdog expires: no error, real data
        ack_delay = TIMEOUT;
        push_bus(36'h200, 1'b0, 64'h0);
        rd_q.push_back(64'h7777);
        push_rsp(64'h7777, 1'b1);
        send_cmd(8'h00, 8'd1, 36'h200);
        wait_idle("t5b_idle");
        check("t5b_err_count", err_seen, 1);
        ack_delay = 2;

        // 6: TX back-pressure mid-burst
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = 64'hB000 + 64'(i);
            push_bus(36'h300 + 36'(i), 1'b0, 64'h0);
            rd_q.push_back(d);
            push_rsp(d, i == 2);
        end
        send_cmd(8'h00, 8'd3, 36'h300);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
        end
        check("t6_rsp_valid", ok, 1);
        d = rsp_data;
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_data !== d || !rsp_valid || bus_req || cmd_ready) ok = 0;
        end
        check("t6_hold", ok, 1);
        tick();
        rsp_ready = 1'b1;
        wait_idle("t6_idle");

        // Reset in the middle of a write burst
        ack_delay = 6;
        push_bus(36'h400, 1'b1, 64'hABCD);
        send_cmd(8'h01, 8'd3, 36'h400);
        send_wr(64'hABCD);
        tick();
        tick();
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("t7_reset");
        tick();
        rstn = 1'b1;
        ack_delay = 2;
        tick();
        push_bus(36'h600, 1'b1, 64'h600D);
        send_cmd(8'h01, 8'd1, 36'h600);
        send_wr(64'h600D);
        wait_idle("t7_wr_idle");
        push_bus(36'h500, 1'b0, 64'h0);
        rd_q.push_back(64'h5A5A);
        push_rsp(64'h5A5A, 1'b1);
        send_cmd(8'h00, 8'd1, 36'h500);
        wait_idle("t7_rd_idle");

        repeat (3) tick();
        check("bus_queue_drained", bus_exp.size(), 0);
        check("rsp_queue_drained", rsp_exp.size(), 0);
        check("err_total", err_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
